// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD display scanner: a sequential double-dabble converter feeds a
// display register, which is scanned one digit per tick onto a 7-segment
// driver interface with optional leading-zero blanking.

// Single-nibble add-3 correction applied before each double-dabble shift.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    // Nibbles of 5 or more would carry past 9 after doubling, so pre-bias by 3
    always_comb nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module bcd_digit_scanner #(
    parameter int IN_WIDTH      = 12,
    parameter int DIGITS        = 4,
    parameter int CLK_HZ        = 50000000,
    parameter int SCAN_HZ       = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] in_value,
    input  logic                load,
    output logic                busy,
    output logic                overflow,
    output logic [3:0]          digit,
    output logic [DIGITS-1:0]   position,
    output logic                blank
);
    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ITW      = 6;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t                   state_q, state_d;
    logic [IN_WIDTH-1:0]      bin_q, bin_d;
    logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
    logic [ITW-1:0]           iter_q, iter_d;
    logic                     ovf_acc_q, ovf_acc_d;
    logic                     busy_q, busy_d;
    logic                     overflow_q, overflow_d;
    logic [DIGITS-1:0][3:0]   disp_q, disp_d;

    logic [TW-1:0]            tick_q, tick_d;
    logic [IW-1:0]            idx_q, idx_d, idx_nx;
    logic [3:0]               digit_q, digit_d;
    logic [DIGITS-1:0]        position_q, position_d;
    logic                     blank_q, blank_d;
    logic                     tick;

    // Corrected BCD accumulator, one add-3 cell per nibble
    logic [4*DIGITS-1:0]      adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        bcd_add3 u_add3 (
            .nib_i (bcd_q[g]),
            .nib_o (adj[4*g +: 4])
        );
    end

    // Converter state and display register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            ovf_acc_q  <= ovf_acc_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            disp_q     <= disp_d;
        end
    end

    // Next-state: accept a load, run IN_WIDTH shift-add-3 steps, then commit
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        disp_d     = disp_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d     = in_value;
                    bcd_d     = '0;
                    iter_d    = '0;
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // A bit leaving the top nibble means the value needs another digit
                bcd_d     = {adj[4*DIGITS-2:0], bin_q[IN_WIDTH-1]};
                bin_d     = bin_q << 1;
                ovf_acc_d = ovf_acc_q | adj[4*DIGITS-1];
                iter_d    = iter_q + ITW'(1);
                if (iter_q == ITW'(IN_WIDTH - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (ovf_acc_q || (bcd_q[DIGITS-1] > 4'd9)) begin
                    disp_d     = {DIGITS{4'd9}};
                    overflow_d = 1'b1;
                end else begin
                    disp_d     = bcd_q;
                    overflow_d = 1'b0;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan counter, index and registered digit outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= '0;
            idx_q      <= '0;
            digit_q    <= 4'd0;
            position_q <= DIGITS'(1);
            blank_q    <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            position_q <= position_d;
            blank_q    <= blank_d;
        end
    end

    // On each tick advance the index and latch that digit from the display
    always_comb begin
        tick       = (tick_q == TW'(TICK_DIV - 1));
        tick_d     = tick ? '0 : tick_q + TW'(1);
        idx_nx     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        idx_d      = idx_q;
        digit_d    = digit_q;
        position_d = position_q;
        blank_d    = blank_q;
        if (tick) begin
            idx_d      = idx_nx;
            digit_d    = 4'd0;
            position_d = '0;
            for (int j = 0; j < DIGITS; j++) begin
                if (idx_nx == IW'(j)) begin
                    digit_d       = disp_q[j];
                    position_d[j] = 1'b1;
                end
            end
            // Blank when this and every more significant nibble is zero
            blank_d = 1'b0;
            if ((BLANK_LEADING != 0) && (idx_nx != '0)) begin
                blank_d = 1'b1;
                for (int j = 0; j < DIGITS; j++) begin
                    if ((IW'(j) >= idx_nx) && (disp_q[j] != 4'd0)) blank_d = 1'b0;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign digit    = digit_q;
    assign position = position_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Randomised bench for bcd_digit_scanner: two instances (blanking on/off)
// compared every cycle against an integer-arithmetic reference model.
module tb_bcd_digit_scanner;
    localparam int IN_WIDTH = 14;
    localparam int DIGITS   = 4;
    localparam int CLK_HZ   = 8;
    localparam int SCAN_HZ  = 2;
    localparam int TICK     = CLK_HZ / SCAN_HZ;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [IN_WIDTH-1:0] in_value = '0;
    logic                load = 1'b0;

    logic                busy, overflow, blank;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   position;
    logic                busy_nb, overflow_nb, blank_nb;
    logic [3:0]          digit_nb;
    logic [DIGITS-1:0]   position_nb;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_digit_scanner #(
        .IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ),
        .SCAN_HZ(SCAN_HZ), .BLANK_LEADING(1)
    ) u_dut (
        .clk(clk), .rst(rst), .in_value(in_value), .load(load),
        .busy(busy), .overflow(overflow), .digit(digit),
        .position(position), .blank(blank)
    );

    bcd_digit_scanner #(
        .IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ),
        .SCAN_HZ(SCAN_HZ), .BLANK_LEADING(0)
    ) u_dut_nb (
        .clk(clk), .rst(rst), .in_value(in_value), .load(load),
        .busy(busy_nb), .overflow(overflow_nb), .digit(digit_nb),
        .position(position_nb), .blank(blank_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r *= 10;
        return r;
    endfunction

    function automatic int nidx(input int i);
        return (i + 1) % DIGITS;
    endfunction

    // Reference model: integer display value, countdown to commit, scan position
    int m_cnt, m_val, m_disp, m_tick, m_idx, m_digit, m_pos;
    bit m_busy, m_ovf, m_blank;

    // Model advances on the same edges as the design, reset asynchronously
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_cnt <= 0; m_val <= 0; m_disp <= 0; m_ovf <= 0;
            m_tick <= 0; m_idx <= 0; m_digit <= 0; m_pos <= 1; m_blank <= 0;
        end else begin
            if (!m_busy) begin
                if (load) begin
                    m_busy <= 1;
                    m_val  <= int'(in_value);
                    m_cnt  <= IN_WIDTH + 1;
                end
            end else if (m_cnt == 1) begin
                m_busy <= 0;
                if (m_val >= pow10(DIGITS)) begin
                    m_disp <= pow10(DIGITS) - 1;
                    m_ovf  <= 1;
                end else begin
                    m_disp <= m_val;
                    m_ovf  <= 0;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
            if (m_tick == TICK - 1) begin
                m_tick  <= 0;
                m_idx   <= nidx(m_idx);
                m_digit <= (m_disp / pow10(nidx(m_idx))) % 10;
                m_pos   <= 1 << nidx(m_idx);
                m_blank <= (nidx(m_idx) != 0) && ((m_disp / pow10(nidx(m_idx))) == 0);
            end else begin
                m_tick <= m_tick + 1;
            end
        end
    end

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        chk("busy",     32'(busy),        32'(m_busy));
        chk("overflow", 32'(overflow),    32'(m_ovf));
        chk("digit",    32'(digit),       32'(m_digit));
        chk("position", 32'(position),    32'(m_pos));
        chk("blank",    32'(blank),       32'(m_blank));
        chk("busy_nb",  32'(busy_nb),     32'(m_busy));
        chk("ovf_nb",   32'(overflow_nb), 32'(m_ovf));
        chk("digit_nb", 32'(digit_nb),    32'(m_digit));
        chk("pos_nb",   32'(position_nb), 32'(m_pos));
        chk("blank_nb", 32'(blank_nb),    32'(0));
    end

    task automatic do_load(input int v, input int hold);
        @(negedge clk);
        in_value = IN_WIDTH'(v);
        load     = 1'b1;
        repeat (hold) @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mid-cycle reset: outputs must return to reset values with no clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_busy"}, 32'(busy),     32'(0));
        chk({tag, "_ovf"},  32'(overflow), 32'(0));
        chk({tag, "_dig"},  32'(digit),    32'(0));
        chk({tag, "_pos"},  32'(position), 32'(1));
        chk({tag, "_blk"},  32'(blank),    32'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam int SETTLE = IN_WIDTH + 2 + 2 * DIGITS * TICK;

    initial begin
        int n;
        int v;
        wait_cyc(3);
        rst = 1'b0;

        // 1234: busy lasts IN_WIDTH+1 cycles
        do_load(1234, 1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(IN_WIDTH + 1));
        wait_cyc(SETTLE);
        chk("ovf_1234", 32'(overflow), 32'(0));

        do_load(7, 1);     wait_cyc(SETTLE);
        do_load(0, 1);     wait_cyc(SETTLE);

        do_load(12000, 1); wait_cyc(SETTLE);
        chk("ovf_12000", 32'(overflow), 32'(1));
        chk("dig_12000", 32'(digit),    32'(9));
        do_load(42, 1);    wait_cyc(SETTLE);
        chk("ovf_42",    32'(overflow), 32'(0));

        // Load while busy is dropped
        do_load(1234, 1);
        wait_cyc(2);
        do_load(5678, 1);
        wait_cyc(SETTLE);

        // Reset during conversion, then a clean conversion
        do_load(1234, 1);  wait_cyc(SETTLE);
        do_load(5678, 1);
        wait_cyc(4);
        async_reset("rst_conv");
        wait_cyc(2 * DIGITS * TICK);
        do_load(5678, 1);  wait_cyc(SETTLE);

        // Boundary values around 10^DIGITS
        do_load(9999, 1);  wait_cyc(SETTLE);
        do_load(10000, 1); wait_cyc(SETTLE);
        do_load(16383, 1); wait_cyc(SETTLE);

        // Random loads, gaps, held loads and occasional resets
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(9990, 10010));
                default: v = int'($urandom_range(0, 16383));
            endcase
            do_load(v, int'($urandom_range(1, 3)));
            wait_cyc(int'($urandom_range(0, 40)));
            if ($urandom_range(0, 14) == 0) async_reset("rst_rand");
        end
        wait_cyc(SETTLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
- Parametrised successor to the fixed 4-digit, 12-bit digit-at-position decoder used by the ADC display path.
- Converts a binary value to BCD with a sequential shift-add-3 (double-dabble) engine, so there are no divide or modulo operators.
- Holds the result in a display register and time-multiplexes the digits to a 7-segment driver at a programmable scan rate.
- Adds a load/busy handshake, optional leading-zero blanking, overflow saturation and a reset.

Parameters:
- IN_WIDTH, 12: width of the binary input, 1..32.
- DIGITS, 4: number of display digits and one-hot position width, 1..8.
- CLK_HZ, 50000000: input clock frequency in Hz.
- SCAN_HZ, 1000: digit-advance rate in Hz; tick period is CLK_HZ/SCAN_HZ cycles, which must be at least 1.
- BLANK_LEADING, 1: 1 enables leading-zero blanking; 0 always shows all digits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_value  input  IN_WIDTH  binary value to display, sampled on an accepted load.
- load  input  1  single-cycle request to convert in_value.
- busy  output  1  conversion in progress; load is ignored while high.
- overflow  output  1  last committed value was at least 10^DIGITS.
- digit  output  4  BCD digit for the currently selected position.
- position  output  DIGITS  one-hot digit select; bit 0 is the least significant digit.
- blank  output  1  the current digit must be blanked by the segment driver.

Behaviour:
- Reset values (async, all registers): busy=0, overflow=0, digit=0, position=1, blank=0.
  - Display register clears to all zeros, scan index to 0, tick counter to 0.
  - FSM goes to IDLE.
  - Reset during CONVERT abandons the conversion; the display register is not updated.
- FSM states:
  - IDLE: load=1 latches in_value into the shift register, clears the BCD accumulator (4*DIGITS bits) and goes to CONVERT.
    - busy goes to 1 on that same edge.
  - CONVERT: runs exactly IN_WIDTH iterations, one per clock. Each iteration adds 3 to every BCD nibble that is at least 5, then shifts {bcd, bin} left by 1.
    - Overflow is detected when a 1 is shifted out of the top nibble, or a top nibble ends above 9. This is equivalent to in_value >= 10^DIGITS.
    - After the last iteration, go to COMMIT.
  - COMMIT (1 cycle):
    - If there is no overflow: copy the BCD result to the display register and set overflow=0.
    - If there is overflow: load all nibbles with 9 and set overflow=1.
    - Set busy=0 and return to IDLE.
- Latency: load accepted at edge N gives busy=1 from N to N+IN_WIDTH+1, and the display is updated at edge N+IN_WIDTH+1.
  - The next load is accepted at edge N+IN_WIDTH+2 at the earliest.
- Handshake:
  - load while busy=1 is dropped silently, with no queueing.
  - load held high across multiple IDLE cycles starts a new conversion each time the FSM is in IDLE.
- Scan:
  - The tick counter counts 0..CLK_HZ/SCAN_HZ-1 and wraps.
  - On the wrap cycle, the scan index advances and wraps from DIGITS-1 to 0.
  - digit, position and blank are registered from the new index and the display register on that same edge.
  - Outputs change only on ticks, so a COMMIT becomes visible at the next tick. Scanning never stops during conversion.
- Blanking (BLANK_LEADING=1):
  - blank=1 for index k>0 when the display nibbles k..DIGITS-1 are all zero.
  - Index 0 is never blanked, so value 0 shows a single "0".
  - With BLANK_LEADING=0, blank is always 0.
- DIGITS=1: position is constantly 1 and the index never changes.
- Arithmetic: the add-3 correction uses unsigned 4-bit values. in_value is treated as unsigned.

Test Plan:
(All scenarios use IN_WIDTH=14, DIGITS=4, CLK_HZ=8, SCAN_HZ=2, so a tick occurs every 4 cycles.)
- Load 1234 in IDLE -> busy high for 15 edges, overflow=0. Successive ticks show (digit, position) = (4, 0001), (3, 0010), (2, 0100), (1, 1000), then wrap to (4, 0001); blank=0 throughout.
- Load 7 with BLANK_LEADING=1 -> position 0001 shows digit 7 with blank=0; positions 0010, 0100 and 1000 show blank=1. With BLANK_LEADING=0, all blank=0 and digits read 7, 0, 0, 0.
- Load 0 -> position 0001 shows digit 0 with blank=0; the other three positions show blank=1.
- Load 12000 -> overflow=1 after commit and every digit reads 9. A following load of 42 clears overflow and shows 2, 4, then blanks.
- Load 1234, then pulse load with 5678 three cycles later -> the second load is ignored and the display shows 1234.
- Load 1234 to completion, load 5678, assert rst at cycle 5 of the conversion -> all outputs take their reset values immediately with no clock edge. After rst is released, the display shows 0, and a fresh load of 5678 completes normally.
